// File: rtl/pwm_duty_ramp.sv
// Soft-start duty generator: walks the PWM on-time toward a loaded target in
// bounded steps at a programmable update interval, with busy/done status.
module pwm_duty_ramp #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] step,
    input  logic [DIV_W-1:0] tick_div,
    output logic [WIDTH-1:0] cycle_on,
    output logic             busy,
    output logic             done
);

    localparam logic IDLE = 1'b0;
    localparam logic RAMP = 1'b1;

    logic             state_reg, state_next;
    logic [WIDTH-1:0] on_reg, on_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [WIDTH-1:0] tgt_reg, tgt_next;
    logic [WIDTH-1:0] step_reg, step_next;
    logic [DIV_W-1:0] div_reg, div_next;

    logic [WIDTH-1:0] step_eff;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   down_floor;
    logic [WIDTH-1:0] stepped;

    // A zero step would stall the ramp forever, so it is promoted to 1.
    assign step_eff = (step == '0) ? WIDTH'(1) : step;

    // One extra bit keeps the sums from wrapping near full scale or zero.
    assign up_sum     = {1'b0, on_reg} + {1'b0, step_reg};
    assign down_floor = {1'b0, tgt_reg} + {1'b0, step_reg};

    always_comb begin
        stepped = on_reg;
        if (tgt_reg > on_reg) begin
            stepped = (up_sum >= {1'b0, tgt_reg}) ? tgt_reg : up_sum[WIDTH-1:0];
        end else begin
            stepped = ({1'b0, on_reg} <= down_floor) ? tgt_reg : (on_reg - step_reg);
        end
    end

    always_comb begin
        state_next   = state_reg;
        on_next      = on_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        div_cnt_next = div_cnt_reg;
        tgt_next     = tgt_reg;
        step_next    = step_reg;
        div_next     = div_reg;

        if (!enable) begin
            state_next   = IDLE;
            on_next      = '0;
            busy_next    = 1'b0;
            div_cnt_next = '0;
        end else if (load) begin
            // A load always wins, even over an update that would finish the ramp.
            tgt_next     = target;
            step_next    = step_eff;
            div_next     = tick_div;
            div_cnt_next = '0;
            if (target == on_reg) begin
                state_next = IDLE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
            end else begin
                state_next = RAMP;
                busy_next  = 1'b1;
            end
        end else if (state_reg == RAMP) begin
            if (div_cnt_reg == div_reg) begin
                div_cnt_next = '0;
                on_next      = stepped;
                if (stepped == tgt_reg) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end else begin
                div_cnt_next = div_cnt_reg + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            on_reg      <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            div_cnt_reg <= '0;
            tgt_reg     <= '0;
            step_reg    <= '0;
            div_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            on_reg      <= on_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            div_cnt_reg <= div_cnt_next;
            tgt_reg     <= tgt_next;
            step_reg    <= step_next;
            div_reg     <= div_next;
        end
    end

    assign cycle_on = on_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule
